// File: rtl/fact_input_ctrl_if.sv
// fact_input_ctrl_if
//   Bundles the raw board inputs and the conditioned control outputs of the
//   factorization game's input front end.
//   master : drives KEY_N/SW (board side), observes the conditioned outputs
//   slave  : the input controller itself
//   KEY_N[1:0] raw buttons, active-low ([0]=decide, [1]=clear)
//   SW[6:0]    raw switches ([1:0]=hp, [4:2]=select, [5]=ready, [6]=question)
//   HP, READY, QUE  debounced levels
//   DEC, CLR        single-cycle press pulses
//   SEL[2:0]        one-hot single-cycle select pulses
interface fact_input_ctrl_if;
    logic [1:0] KEY_N;
    logic [6:0] SW;
    logic [1:0] HP;
    logic       READY;
    logic       QUE;
    logic       DEC;
    logic       CLR;
    logic [2:0] SEL;

    modport master (
        output KEY_N, SW,
        input  HP, READY, QUE, DEC, CLR, SEL
    );

    modport slave (
        input  KEY_N, SW,
        output HP, READY, QUE, DEC, CLR, SEL
    );
endinterface

// File: rtl/fact_input_ctrl.sv
// fact_input_ctrl
//   Synchronizes and debounces the board buttons and switches, then turns
//   them into the level and pulse controls consumed by JOIN.
//   CLK  system clock
//   RST  synchronous active-high reset
//   bus  fact_input_ctrl_if.slave: KEY_N/SW in; HP/READY/QUE/DEC/CLR/SEL out
//   All outputs come straight from flops.
module fact_input_ctrl #(
    parameter int DEB_CNT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    fact_input_ctrl_if.slave  bus
);

    // Channel map: [0]=decide key, [1]=clear key, [8:2]=SW[6:0]
    localparam int               NCH      = 9;
    localparam logic [NCH-1:0]   IDLE     = 9'b0_0000_0011;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   sync1;
    logic [NCH-1:0]   sync2;
    logic [NCH-1:0]   stab;
    logic [CNT_W-1:0] cnt [NCH];

    logic [1:0] key_prev;
    logic [2:0] sel_prev;
    logic [2:0] pending;
    logic       dec_q;
    logic       clr_q;
    logic [2:0] sel_q;

    logic       armed;
    logic       dec_event;
    logic       clr_event;
    logic [2:0] sel_edge;
    logic [2:0] pend_all;
    logic [2:0] lowest;

    assign raw = {bus.SW, bus.KEY_N};

    // Debounce: a channel's stable value only follows the synchronized value
    // after DEB_CNT consecutive cycles of disagreement.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
            stab  <= IDLE;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == stab[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    // this increment would reach DEB_CNT: commit the new value
                    stab[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        armed     = stab[7] & stab[8];
        dec_event = key_prev[0] & ~stab[0];
        clr_event = key_prev[1] & ~stab[1];
        sel_edge  = stab[6:4] & ~sel_prev;
        pend_all  = pending | sel_edge;
        // isolate the lowest set bit so SEL is never multi-hot
        lowest    = pend_all & (~pend_all + 3'd1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            key_prev <= 2'b11;
            sel_prev <= 3'b000;
            pending  <= 3'b000;
            dec_q    <= 1'b0;
            clr_q    <= 1'b0;
            sel_q    <= 3'b000;
        end else begin
            key_prev <= stab[1:0];
            sel_prev <= stab[6:4];
            clr_q    <= clr_event;
            // a clear in the same cycle wins over decide
            dec_q    <= dec_event & armed & ~clr_event;
            if (!armed || clr_event) begin
                pending <= 3'b000;
                sel_q   <= 3'b000;
            end else begin
                pending <= pend_all & ~lowest;
                sel_q   <= lowest;
            end
        end
    end

    assign bus.HP    = stab[3:2];
    assign bus.READY = stab[7];
    assign bus.QUE   = stab[8];
    assign bus.DEC   = dec_q;
    assign bus.CLR   = clr_q;
    assign bus.SEL   = sel_q;

endmodule

// File: tb/tb_fact_input_ctrl.sv
module tb_fact_input_ctrl;

    localparam int LAT = 18;    // raw change -> pulse, in clock edges

    logic CLK;
    logic RST;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int         cyc;
        logic [4:0] val;        // {CLR, DEC, SEL[2:0]}
    } ev_t;

    ev_t        sb[$];
    logic [4:0] obs;
    logic [4:0] expv;
    logic       due;

    fact_input_ctrl_if bus ();

    fact_input_ctrl #(.DEB_CNT(15), .CNT_W(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Pulse scoreboard: every pulse (or expected pulse) is compared in the
    // exact cycle the bench predicted.
    always @(negedge CLK) begin
        obs  = {bus.CLR, bus.DEC, bus.SEL};
        due  = (sb.size() > 0) && (sb[0].cyc == cyc);
        expv = due ? sb[0].val : 5'b00000;
        if (due) void'(sb.pop_front());
        if (due || obs !== 5'b00000) begin
            checks++;
            assert (obs === expv) else begin
                errors++;
                $error("FAIL pulse cycle %0d: got %b expected %b", cyc, obs, expv);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic idle(input int n);
        goto(cyc + n);
    endtask

    task automatic expect_pulse(input int c, input logic [4:0] v);
        sb.push_back('{cyc: c, val: v});
    endtask

    task automatic check_levels(input string tag, input logic [1:0] hp, input logic rdy, input logic que);
        check({tag, "_hp"},    32'(bus.HP),    32'(hp));
        check({tag, "_ready"}, 32'(bus.READY), 32'(rdy));
        check({tag, "_que"},   32'(bus.QUE),   32'(que));
    endtask

    initial begin
        int t;
        int r;
        RST       = 1'b1;
        bus.KEY_N = 2'b11;
        bus.SW    = 7'd0;
        goto(3);
        check_levels("reset", 2'b00, 1'b0, 1'b0);
        check("reset_pulses", 32'({bus.CLR, bus.DEC, bus.SEL}), 32'd0);
        RST = 1'b0;

        // idle: nothing may move
        for (int i = 0; i < 10; i++) begin
            idle(10);
            check_levels("idle", 2'b00, 1'b0, 1'b0);
        end

        // arm and set hp; READY/QUE rise exactly 17 edges after the change
        bus.SW[6:5] = 2'b11;
        bus.SW[1:0] = 2'b10;
        t = cyc;
        goto(t + 16);
        check_levels("arm_early", 2'b00, 1'b0, 1'b0);
        goto(t + 17);
        check_levels("arm_done", 2'b10, 1'b1, 1'b1);
        idle(10);

        // single select edge, held high afterwards
        bus.SW[2] = 1'b1;
        expect_pulse(cyc + LAT, 5'b00001);
        idle(40);
        bus.SW[2] = 1'b0;           // falling edge is ignored
        idle(30);

        // three simultaneous edges come out lowest index first
        bus.SW[4:2] = 3'b111;
        t = cyc;
        expect_pulse(t + LAT,     5'b00001);
        expect_pulse(t + LAT + 1, 5'b00010);
        expect_pulse(t + LAT + 2, 5'b00100);
        idle(40);
        bus.SW[4:2] = 3'b000;
        idle(30);

        // chatter on decide never passes; the final hold gives one DEC
        for (int b = 0; b < 3; b++) begin
            bus.KEY_N[0] = 1'b0;
            idle(8);
            bus.KEY_N[0] = 1'b1;
            idle(8);
        end
        bus.KEY_N[0] = 1'b0;
        expect_pulse(cyc + LAT, 5'b01000);
        idle(40);
        bus.KEY_N[0] = 1'b1;        // release: no pulse
        idle(40);

        // disarmed: decide and select edge are dropped
        bus.SW[5] = 1'b0;
        idle(30);
        check_levels("disarmed", 2'b10, 1'b0, 1'b1);
        bus.KEY_N[0] = 1'b0;
        bus.SW[3]    = 1'b1;
        idle(40);
        bus.SW[5] = 1'b1;           // re-arm: discarded edge stays discarded
        idle(40);
        check_levels("rearmed", 2'b10, 1'b1, 1'b1);
        bus.KEY_N[0] = 1'b1;
        idle(30);

        // clear is honoured while disarmed
        bus.SW[5] = 1'b0;
        idle(30);
        bus.KEY_N[1] = 1'b0;
        expect_pulse(cyc + LAT, 5'b10000);
        idle(40);
        bus.KEY_N[1] = 1'b1;
        idle(30);

        // prepare: no select high, armed
        bus.SW[4:2] = 3'b000;
        bus.SW[5]   = 1'b1;
        idle(30);

        // clear held through a reset pulse
        bus.KEY_N[1] = 1'b0;
        expect_pulse(cyc + LAT, 5'b10000);
        idle(40);
        RST = 1'b1;
        r = cyc;
        goto(r + 1);
        RST = 1'b0;
        check_levels("after_rst", 2'b00, 1'b0, 1'b0);
        check("after_rst_pulses", 32'({bus.CLR, bus.DEC, bus.SEL}), 32'd0);
        expect_pulse(cyc + LAT, 5'b10000);
        t = cyc;
        goto(t + 17);
        check_levels("rst_rearm", 2'b10, 1'b1, 1'b1);
        idle(30);
        bus.KEY_N[1] = 1'b1;
        idle(30);

        // both keys together while armed: clear wins, decide suppressed
        bus.KEY_N = 2'b00;
        expect_pulse(cyc + LAT, 5'b10000);
        idle(40);
        bus.KEY_N = 2'b11;
        idle(40);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
